// File: rtl/cpu_datapath_if.sv
// Control and observation bundle of the single-bus CPU datapath.
// The master side (control unit or bench) drives load enables, bus selects,
// ALU strobes and memory read data. The slave side (the datapath) returns
// the bus value and the register views.
interface cpu_datapath_if #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) ();
  localparam int TOT_REGISTERS = REGISTERS + 6;

  // Register load enables
  logic PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin;
  logic Read;

  // Bus drive selects
  logic MDRout, LOout, HIout, Zhighout, Zlowout, PCout;

  // ALU operation strobes, listed in priority order
  logic ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC;

  // General-purpose register enables and selects
  logic [REGISTERS-1:0] GPRin;
  logic [REGISTERS-1:0] GPRout;

  // Memory read data
  logic [BITS-1:0] Mdatain;

  // Observation outputs
  logic [BITS*TOT_REGISTERS-1:0] regSelectStream;
  logic [BITS-1:0]               bus;
  logic [BITS-1:0]               MARVal;
  logic [2*BITS-1:0]             RZVal;
  logic [BITS-1:0]               IRVal;

  modport master (
    output PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
    output MDRout, LOout, HIout, Zhighout, Zlowout, PCout,
    output ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
    output GPRin, GPRout, Mdatain,
    input  regSelectStream, bus, MARVal, RZVal, IRVal
  );

  modport slave (
    input  PCin, IRin, RYin, RZin, MARin, HIin, LOin, MDRin, Read,
    input  MDRout, LOout, HIout, Zhighout, Zlowout, PCout,
    input  ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, AND, OR, NEGATE, NOT, IncPC,
    input  GPRin, GPRout, Mdatain,
    output regSelectStream, bus, MARVal, RZVal, IRVal
  );
endinterface

// File: rtl/cpu_datapath.sv
// Single-bus CPU datapath: GPR file, PC, IR, MAR, MDR, HI, LO, ALU operand
// register RY and double-width ALU result register RZ, all sharing one bus.
// The bus and the ALU are purely combinational; every register loads on the
// rising clock edge from the bus (MDR may instead take memory data, RZ takes
// the ALU result).
module cpu_datapath #(
  parameter int BITS      = 32,
  parameter int REGISTERS = 16
) (
  input logic           Clock,
  input logic           reset,
  cpu_datapath_if.slave dp
);
  localparam int TOT_REGISTERS = REGISTERS + 6;
  localparam int SHW           = $clog2(BITS);

  logic [BITS-1:0]   gpr_q [REGISTERS];
  logic [BITS-1:0]   gpr_d [REGISTERS];
  logic [BITS-1:0]   pc_q, pc_d, ir_q, ir_d, ry_q, ry_d, mar_q, mar_d;
  logic [BITS-1:0]   mdr_q, mdr_d, hi_q, hi_d, lo_q, lo_d;
  logic [2*BITS-1:0] rz_q, rz_d;

  logic [BITS-1:0]   bus_w;
  logic [2*BITS-1:0] alu_r;

  logic [2*BITS-1:0]      a_ext, b_ext, rot_l, rot_r;
  logic [SHW-1:0]         shamt;
  logic signed [BITS-1:0] quot, rem;

  logic [BITS*TOT_REGISTERS-1:0] stream;

  // Bus mux: sources are applied lowest priority first so the highest
  // priority active select is the last one written and wins.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments so later statements see earlier results.
    // NOTE: every signal gets a default before any condition, so no latch is inferred.
    bus_w = '0;
    if (dp.Zlowout)  bus_w = rz_q[BITS-1:0];
    if (dp.Zhighout) bus_w = rz_q[2*BITS-1:BITS];
    if (dp.LOout)    bus_w = lo_q;
    if (dp.HIout)    bus_w = hi_q;
    if (dp.MDRout)   bus_w = mdr_q;
    if (dp.PCout)    bus_w = pc_q;
    for (int i = REGISTERS - 1; i >= 0; i--) begin
      if (dp.GPRout[i]) bus_w = gpr_q[i];
    end
  end

  // ALU operands: A is RY, B is the bus. Rotates use a doubled copy of A so
  // the wrapped bits fall out of a plain shift.
  assign a_ext = {{BITS{ry_q[BITS-1]}}, ry_q};
  assign b_ext = {{BITS{bus_w[BITS-1]}}, bus_w};
  assign shamt = bus_w[SHW-1:0];
  assign rot_l = {ry_q, ry_q} << shamt;
  assign rot_r = {ry_q, ry_q} >> shamt;
  assign quot  = $signed(ry_q) / $signed(bus_w);
  assign rem   = $signed(ry_q) % $signed(bus_w);

  // ALU result select, strobes in fixed priority order
  always_comb begin
    alu_r = '0;
    if (dp.ADD)         alu_r = a_ext + b_ext;
    else if (dp.SUB)    alu_r = a_ext - b_ext;
    else if (dp.MUL)    alu_r = a_ext * b_ext;
    else if (dp.DIV)    alu_r = (bus_w == '0) ? '0 : {rem, quot};
    else if (dp.SHR)    alu_r = {{BITS{1'b0}}, ry_q >> shamt};
    else if (dp.SHL)    alu_r = {{BITS{1'b0}}, ry_q << shamt};
    else if (dp.ROR)    alu_r = {{BITS{1'b0}}, rot_r[BITS-1:0]};
    else if (dp.ROL)    alu_r = {{BITS{1'b0}}, rot_l[2*BITS-1:BITS]};
    else if (dp.AND)    alu_r = {{BITS{1'b0}}, ry_q & bus_w};
    else if (dp.OR)     alu_r = {{BITS{1'b0}}, ry_q | bus_w};
    else if (dp.NEGATE) alu_r = '0 - b_ext;
    else if (dp.NOT)    alu_r = {{BITS{1'b0}}, ~bus_w};
    else if (dp.IncPC)  alu_r = {{BITS{1'b0}}, bus_w + BITS'(1)};
  end

  // Next-state for every register: hold unless its load enable is set
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    ry_d  = ry_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    rz_d  = rz_q;
    for (int i = 0; i < REGISTERS; i++) begin
      gpr_d[i] = dp.GPRin[i] ? bus_w : gpr_q[i];
    end
    if (dp.PCin)  pc_d  = bus_w;
    if (dp.IRin)  ir_d  = bus_w;
    if (dp.RYin)  ry_d  = bus_w;
    if (dp.MARin) mar_d = bus_w;
    if (dp.HIin)  hi_d  = bus_w;
    if (dp.LOin)  lo_d  = bus_w;
    if (dp.MDRin) mdr_d = dp.Read ? dp.Mdatain : bus_w;
    if (dp.RZin)  rz_d  = alu_r;
  end

  // Register update with synchronous reset overriding all loads
  always_ff @(posedge Clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      ry_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      rz_q  <= '0;
      // NOTE: the register file is reset explicitly because software may read any GPR straight after reset.
      for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      ry_q  <= ry_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      rz_q  <= rz_d;
      for (int i = 0; i < REGISTERS; i++) gpr_q[i] <= gpr_d[i];
    end
  end

  // Observation stream {MDR, LO, HI, RY, IR, PC, R(n-1)..R0}, R0 in the LSBs
  always_comb begin
    stream = '0;
    for (int i = 0; i < REGISTERS; i++) stream[i*BITS +: BITS] = gpr_q[i];
    stream[(REGISTERS+0)*BITS +: BITS] = pc_q;
    stream[(REGISTERS+1)*BITS +: BITS] = ir_q;
    stream[(REGISTERS+2)*BITS +: BITS] = ry_q;
    stream[(REGISTERS+3)*BITS +: BITS] = hi_q;
    stream[(REGISTERS+4)*BITS +: BITS] = lo_q;
    stream[(REGISTERS+5)*BITS +: BITS] = mdr_q;
  end

  assign dp.regSelectStream = stream;
  assign dp.bus             = bus_w;
  assign dp.MARVal          = mar_q;
  assign dp.RZVal           = rz_q;
  assign dp.IRVal           = ir_q;
endmodule

// File: tb/tb_cpu_datapath.sv
// Testbench for cpu_datapath: directed sequences with literal expectations,
// then randomized control words. A behavioural model of the register set
// is updated on every rising edge and compared with all DUT outputs on
// every falling edge.
module tb_cpu_datapath;
  localparam int BITS = 32;
  localparam int NREG = 16;
  localparam int NFLD = NREG + 6;

  // Bit positions inside the packed stimulus vectors
  localparam int L_PC = 7, L_IR = 6, L_RY = 5, L_RZ = 4, L_MAR = 3, L_HI = 2, L_LO = 1, L_MDR = 0;
  localparam int O_MDR = 5, O_LO = 4, O_HI = 3, O_ZH = 2, O_ZL = 1, O_PC = 0;
  localparam int P_ADD = 12, P_SUB = 11, P_MUL = 10, P_DIV = 9, P_SHR = 8, P_SHL = 7, P_ROR = 6;
  localparam int P_ROL = 5, P_AND = 4, P_OR = 3, P_NEG = 2, P_NOT = 1, P_INC = 0;

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      ld;
  logic [5:0]      outs;
  logic [12:0]     ops;
  logic [NREG-1:0] gpr_in, gpr_out;
  logic            rd;
  logic [BITS-1:0] mdatain;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_datapath_if #(.BITS(BITS), .REGISTERS(NREG)) dp ();

  cpu_datapath #(.BITS(BITS), .REGISTERS(NREG)) dut (
    .Clock (clk),
    .reset (rst),
    .dp    (dp)
  );

  assign {dp.PCin, dp.IRin, dp.RYin, dp.RZin, dp.MARin, dp.HIin, dp.LOin, dp.MDRin} = ld;
  assign {dp.MDRout, dp.LOout, dp.HIout, dp.Zhighout, dp.Zlowout, dp.PCout} = outs;
  assign {dp.ADD, dp.SUB, dp.MUL, dp.DIV, dp.SHR, dp.SHL, dp.ROR, dp.ROL,
          dp.AND, dp.OR, dp.NEGATE, dp.NOT, dp.IncPC} = ops;
  assign dp.GPRin   = gpr_in;
  assign dp.GPRout  = gpr_out;
  assign dp.Read    = rd;
  assign dp.Mdatain = mdatain;

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_gpr [NREG];
  logic [31:0] m_pc, m_ir, m_ry, m_mar, m_mdr, m_hi, m_lo;
  logic [63:0] m_rz;
  bit          m_valid = 1'b0;

  function automatic logic [31:0] m_field(input int i);
    if (i < NREG) return m_gpr[i];
    case (i - NREG)
      0: return m_pc;
      1: return m_ir;
      2: return m_ry;
      3: return m_hi;
      4: return m_lo;
      default: return m_mdr;
    endcase
  endfunction

  function automatic logic [31:0] m_bus();
    for (int i = 0; i < NREG; i++) if (gpr_out[i]) return m_gpr[i];
    if (outs[O_PC])  return m_pc;
    if (outs[O_MDR]) return m_mdr;
    if (outs[O_HI])  return m_hi;
    if (outs[O_LO])  return m_lo;
    if (outs[O_ZH])  return m_rz[63:32];
    if (outs[O_ZL])  return m_rz[31:0];
    return 32'h0;
  endfunction

  function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b, input logic [12:0] op);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    int     s  = int'(b[4:0]);
    int     q, r;
    if (op[P_ADD]) return sa + sb;
    if (op[P_SUB]) return sa - sb;
    if (op[P_MUL]) return sa * sb;
    if (op[P_DIV]) begin
      if (b == 32'h0) return 64'h0;
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    if (op[P_SHR]) return {32'h0, a >> s};
    if (op[P_SHL]) return {32'h0, a << s};
    if (op[P_ROR]) return (s == 0) ? {32'h0, a} : {32'h0, (a >> s) | (a << (32 - s))};
    if (op[P_ROL]) return (s == 0) ? {32'h0, a} : {32'h0, (a << s) | (a >> (32 - s))};
    if (op[P_AND]) return {32'h0, a & b};
    if (op[P_OR])  return {32'h0, a | b};
    if (op[P_NEG]) return -sb;
    if (op[P_NOT]) return {32'h0, ~b};
    if (op[P_INC]) return {32'h0, b + 32'd1};
    return 64'h0;
  endfunction

  // Model update on every rising edge from the stimulus being applied
  always @(posedge clk) begin : model_upd
    logic [31:0] b;
    logic [63:0] r;
    if (rst) begin
      for (int i = 0; i < NREG; i++) m_gpr[i] = 32'h0;
      {m_pc, m_ir, m_ry, m_mar, m_mdr, m_hi, m_lo} = '0;
      m_rz    = 64'h0;
      m_valid = 1'b1;
    end else begin
      b = m_bus();
      r = m_alu(m_ry, b, ops);
      for (int i = 0; i < NREG; i++) if (gpr_in[i]) m_gpr[i] = b;
      if (ld[L_PC])  m_pc  = b;
      if (ld[L_IR])  m_ir  = b;
      if (ld[L_RY])  m_ry  = b;
      if (ld[L_MAR]) m_mar = b;
      if (ld[L_HI])  m_hi  = b;
      if (ld[L_LO])  m_lo  = b;
      if (ld[L_MDR]) m_mdr = rd ? mdatain : b;
      if (ld[L_RZ])  m_rz  = r;
    end
  end

  // Compare all outputs against the model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      for (int i = 0; i < NFLD; i++)
        check($sformatf("field%0d", i), {32'h0, dp.regSelectStream[i*BITS +: BITS]}, {32'h0, m_field(i)});
      check("bus",    {32'h0, dp.bus},    {32'h0, m_bus()});
      check("marval", {32'h0, dp.MARVal}, {32'h0, m_mar});
      check("irval",  {32'h0, dp.IRVal},  {32'h0, m_ir});
      check("rzval",  dp.RZVal,           m_rz);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_ctrl();
    ld = '0; outs = '0; ops = '0; gpr_in = '0; gpr_out = '0; rd = 1'b0; rst = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear_ctrl();
  endtask

  task automatic load_gpr(input int k, input logic [31:0] v);
    rd = 1'b1; ld[L_MDR] = 1'b1; mdatain = v;
    tick();
    outs[O_MDR] = 1'b1; gpr_in[k] = 1'b1;
    tick();
  endtask

  task automatic gpr_to_ry(input int k);
    gpr_out[k] = 1'b1; ld[L_RY] = 1'b1;
    tick();
  endtask

  task automatic alu_op(input int k, input int op);
    gpr_out[k] = 1'b1; ops[op] = 1'b1; ld[L_RZ] = 1'b1;
    tick();
  endtask

  function automatic logic [63:0] dut_field(input int i);
    return {32'h0, dp.regSelectStream[i*BITS +: BITS]};
  endfunction

  initial begin
    int r;
    clear_ctrl();
    mdatain = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Memory read into MDR, then MDR -> bus -> R2
    rd = 1'b1; ld[L_MDR] = 1'b1; mdatain = 32'd22;
    tick();
    check("mdr_read", dut_field(NREG + 5), 64'd22);
    outs[O_MDR] = 1'b1; gpr_in[2] = 1'b1;
    tick();
    check("r2_from_mdr", dut_field(2), 64'd22);

    // ADD 5 + 7, result copied to R3
    load_gpr(1, 32'd5);
    load_gpr(2, 32'd7);
    gpr_to_ry(1);
    alu_op(2, P_ADD);
    check("add_rz", dp.RZVal, 64'd12);
    outs[O_ZL] = 1'b1; gpr_in[3] = 1'b1;
    tick();
    check("add_r3", dut_field(3), 64'd12);

    // MAR and IR loads
    gpr_out[3] = 1'b1; ld[L_MAR] = 1'b1;
    tick();
    check("mar_load", {32'h0, dp.MARVal}, 64'd12);
    gpr_out[1] = 1'b1; ld[L_IR] = 1'b1;
    tick();
    check("ir_load", {32'h0, dp.IRVal}, 64'd5);

    // Bus priority and idle bus
    gpr_out = 16'b0110; outs[O_PC] = 1'b1;
    #1;
    check("prio_gpr_low", {32'h0, dp.bus}, 64'd5);
    gpr_out = '0; outs = '0; outs[O_MDR] = 1'b1; outs[O_LO] = 1'b1;
    #1;
    check("prio_mdr_lo", {32'h0, dp.bus}, 64'd7);
    outs = '0;
    #1;
    check("bus_idle", {32'h0, dp.bus}, 64'd0);

    // MUL / DIV with RY = -6, bus = 4, and DIV by zero
    load_gpr(4, 32'hFFFF_FFFA);
    load_gpr(5, 32'd4);
    gpr_to_ry(4);
    alu_op(5, P_MUL);
    check("mul", dp.RZVal, 64'hFFFF_FFFF_FFFF_FFE8);
    alu_op(5, P_DIV);
    check("div", dp.RZVal, 64'hFFFF_FFFE_FFFF_FFFF);
    ops[P_DIV] = 1'b1; ld[L_RZ] = 1'b1;
    tick();
    check("div_by_zero", dp.RZVal, 64'h0);

    // Shifts and rotates by 1 of 0x80000001
    load_gpr(6, 32'h8000_0001);
    load_gpr(7, 32'd1);
    gpr_to_ry(6);
    alu_op(7, P_ROL);
    check("rol", dp.RZVal, 64'h0000_0000_0000_0003);
    alu_op(7, P_ROR);
    check("ror", dp.RZVal, 64'h0000_0000_C000_0000);
    alu_op(7, P_SHR);
    check("shr", dp.RZVal, 64'h0000_0000_4000_0000);
    alu_op(7, P_SHL);
    check("shl", dp.RZVal, 64'h0000_0000_0000_0002);
    load_gpr(8, 32'd0);
    alu_op(8, P_ROL);
    check("rol_by_zero", dp.RZVal, 64'h0000_0000_8000_0001);

    // ADD overflow: 0x7FFFFFFF + 1 wraps low, high word is positive extension
    load_gpr(9, 32'h7FFF_FFFF);
    gpr_to_ry(9);
    alu_op(7, P_ADD);
    check("add_overflow", dp.RZVal, 64'h0000_0000_8000_0000);

    // PC increment wraps from 0xFFFFFFFF to 0
    rd = 1'b1; ld[L_MDR] = 1'b1; mdatain = 32'hFFFF_FFFF;
    tick();
    outs[O_MDR] = 1'b1; ld[L_PC] = 1'b1;
    tick();
    check("pc_load", dut_field(NREG), 64'hFFFF_FFFF);
    outs[O_PC] = 1'b1; ops[P_INC] = 1'b1; ld[L_RZ] = 1'b1;
    tick();
    check("incpc_rz", dp.RZVal, 64'h0);
    outs[O_ZL] = 1'b1; ld[L_PC] = 1'b1;
    tick();
    check("pc_wrap", dut_field(NREG), 64'h0);

    // Reset mid-sequence overrides active loads
    load_gpr(10, 32'hDEAD_BEEF);
    gpr_out[10] = 1'b1; ops[P_NOT] = 1'b1; ld[L_RZ] = 1'b1;
    tick();
    rd = 1'b1; ld[L_MDR] = 1'b1; mdatain = 32'h1234_5678; gpr_in = '1; outs[O_MDR] = 1'b1; rst = 1'b1;
    tick();
    for (int i = 0; i < NFLD; i++) check($sformatf("reset_field%0d", i), dut_field(i), 64'h0);
    check("reset_rz",  dp.RZVal, 64'h0);
    check("reset_mar", {32'h0, dp.MARVal}, 64'h0);

    // Randomized control words
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst = ($urandom_range(63) == 0);
      rd  = 1'($urandom);
      case ($urandom_range(3))
        0:       mdatain = 32'h8000_0000;
        1:       mdatain = 32'($urandom_range(40));
        default: mdatain = $urandom;
      endcase
      ld     = 8'($urandom) & 8'($urandom);
      gpr_in = 16'($urandom) & 16'($urandom) & 16'($urandom);
      case ($urandom_range(3))
        0:       gpr_out = 16'(1 << $urandom_range(NREG - 1));
        1:       outs = 6'(1 << $urandom_range(5));
        2:       begin gpr_out = 16'($urandom) & 16'($urandom); outs = 6'($urandom); end
        default: ;
      endcase
      r = $urandom_range(14);
      if (r < 13)       ops = 13'(1 << r);
      else if (r == 13) ops = 13'($urandom);
      // Signed MIN / -1 has no representable quotient; keep DIV off that operand
      if (m_ry == 32'h8000_0000) ops[P_DIV] = 1'b0;
      tick();
    end

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
